// File: rtl/mii_tx_arbiter.sv
// -----------------------------------------------------------------------------
// mii_tx_arbiter
//
// Shares one MII transmit nibble interface between two byte-stream
// requesters. Arbitration is per frame and round-robin: when both requesters
// are waiting in IDLE, the one that was not served last wins (requester 0
// after reset). Each granted frame goes out as PREAMBLE_NIBBLES nibbles of
// 4'h5, one 4'hD SFD nibble, and then each byte as two nibbles, low nibble
// first. Every frame is followed by IFG_NIBBLES idle cycles with tx_en low.
//
// Ports:
//   clk          MII TX clock, all logic on the rising edge
//   rst          synchronous, active-high reset
//   reqN_valid   requester N presents a byte
//   reqN_data    requester N byte, sampled only on an accepting edge
//   reqN_last    requester N final byte of frame, sampled with the data
//   reqN_ready   requester N byte is taken this cycle (valid && ready)
//   mii_txd      registered transmit nibble
//   mii_tx_en    registered transmit enable
//   grant        one-hot owner of the interface, 2'b00 while idle
//   busy         high whenever the arbiter is not idle
//   underrun     one-cycle pulse when the owner drops valid mid-frame
//
// PREAMBLE_NIBBLES and IFG_NIBBLES must both be at least 1.
// -----------------------------------------------------------------------------
module mii_tx_arbiter #(
    parameter int PREAMBLE_NIBBLES = 15,
    parameter int IFG_NIBBLES      = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,
    output logic [3:0] mii_txd,
    output logic       mii_tx_en,
    output logic [1:0] grant,
    output logic       busy,
    output logic       underrun
);

    // One counter is shared by the preamble and the inter-frame gap, so it
    // is sized for the longer of the two.
    localparam int CNT_MAX = (PREAMBLE_NIBBLES > IFG_NIBBLES) ?
                             PREAMBLE_NIBBLES : IFG_NIBBLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_NIBBLES - 1);
    localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_NIBBLES - 1);

    localparam logic [3:0] NIB_PREAMBLE = 4'h5;
    localparam logic [3:0] NIB_SFD      = 4'hD;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SFD,
        DATA_LO,
        DATA_HI,
        IFG
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             rr_prefer1;   // 1: requester 1 wins a tie
    logic             cur_last;     // byte on the wire closes the frame
    logic [3:0]       hi_nib;       // upper half of the byte on the wire

    logic [1:0]       arb_grant;
    logic             want_byte;
    logic             sel_valid;
    logic [7:0]       sel_data;
    logic             sel_last;
    logic             accept;
    logic             starve;

    // -------------------------------------------------------------------------
    // Owner selection and handshake
    // -------------------------------------------------------------------------

    // A new byte is wanted in SFD (first byte) and in the high-nibble cycle
    // of every byte that is not the last one of the frame.
    assign want_byte = (state == SFD) || ((state == DATA_HI) && !cur_last);

    assign req0_ready = want_byte && grant[0];
    assign req1_ready = want_byte && grant[1];

    // grant is always one-hot while a byte is wanted, so a single bit is
    // enough to steer the mux.
    assign sel_valid = grant[1] ? req1_valid : req0_valid;
    assign sel_data  = grant[1] ? req1_data  : req0_data;
    assign sel_last  = grant[1] ? req1_last  : req0_last;

    assign accept = want_byte && sel_valid;
    assign starve = want_byte && !sel_valid;

    // Round-robin choice, only acted on in IDLE.
    always_comb begin
        arb_grant = 2'b00;
        if (req0_valid && req1_valid) begin
            arb_grant = rr_prefer1 ? 2'b10 : 2'b01;
        end else if (req0_valid) begin
            arb_grant = 2'b01;
        end else if (req1_valid) begin
            arb_grant = 2'b10;
        end
    end

    // -------------------------------------------------------------------------
    // Frame sequencer with registered MII outputs
    // -------------------------------------------------------------------------

    // Outputs are written together with the state they belong to, so that
    // mii_txd/mii_tx_en always reflect the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            grant      <= 2'b00;
            busy       <= 1'b0;
            mii_tx_en  <= 1'b0;
            mii_txd    <= 4'h0;
            underrun   <= 1'b0;
            rr_prefer1 <= 1'b0;
            cur_last   <= 1'b0;
        end else begin
            underrun <= 1'b0;

            case (state)
                IDLE: begin
                    if (arb_grant != 2'b00) begin
                        state     <= PREAMBLE;
                        cnt       <= '0;
                        grant     <= arb_grant;
                        busy      <= 1'b1;
                        mii_tx_en <= 1'b1;
                        mii_txd   <= NIB_PREAMBLE;
                    end
                end

                PREAMBLE: begin
                    if (cnt == PRE_LAST) begin
                        state   <= SFD;
                        mii_txd <= NIB_SFD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA_LO: begin
                    state   <= DATA_HI;
                    mii_txd <= hi_nib;
                end

                SFD, DATA_HI: begin
                    if (accept) begin
                        state    <= DATA_LO;
                        mii_txd  <= sel_data[3:0];
                        cur_last <= sel_last;
                    end else begin
                        // Either the frame ended normally (last byte done)
                        // or the owner starved us and the frame is cut.
                        state      <= IFG;
                        cnt        <= '0;
                        mii_tx_en  <= 1'b0;
                        mii_txd    <= 4'h0;
                        underrun   <= starve;
                        rr_prefer1 <= grant[0];
                    end
                end

                IFG: begin
                    if (cnt == IFG_LAST) begin
                        state <= IDLE;
                        grant <= 2'b00;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    grant     <= 2'b00;
                    busy      <= 1'b0;
                    mii_tx_en <= 1'b0;
                    mii_txd   <= 4'h0;
                end
            endcase
        end
    end

    // High nibble of the accepted byte, replayed one cycle after the low
    // nibble. Pure data, so it carries no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            hi_nib <= sel_data[7:4];
        end
    end

endmodule

// File: tb/tb_mii_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mii_tx_arbiter
//
// Two byte-stream drivers feed the arbiter from per-requester frame tables.
// A frame-level reference model predicts, for every granted frame, the
// complete cycle-by-cycle trace of tx_en, txd, grant, busy, underrun and the
// two ready lines (preamble, SFD, nibble pairs, gap), and the observed
// outputs are compared against it every cycle.
// -----------------------------------------------------------------------------
module tb_mii_tx_arbiter;

    localparam int PRE = 15;
    localparam int IFG = 24;
    localparam int NF  = 16;

    localparam logic [2:0] K_IDLE = 3'd0;
    localparam logic [2:0] K_PRE  = 3'd1;
    localparam logic [2:0] K_SFD  = 3'd2;
    localparam logic [2:0] K_LO   = 3'd3;
    localparam logic [2:0] K_HI   = 3'd4;
    localparam logic [2:0] K_IFG  = 3'd5;

    // v = {tx_en, txd[3:0], grant[1:0], busy, underrun, ready1, ready0}
    typedef struct packed {
        logic [2:0]  kind;
        logic [10:0] v;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_last, req0_ready;
    logic [7:0] req0_data;
    logic       req1_valid, req1_last, req1_ready;
    logic [7:0] req1_data;
    logic [3:0] mii_txd;
    logic       mii_tx_en;
    logic [1:0] grant;
    logic       busy;
    logic       underrun;

    exp_t       exp_q[$];
    logic [7:0] fb[2][NF][8];
    int         flen[2][NF];
    int         fcut[2][NF];
    int         fdly[2][NF];
    int         nf[2];
    int         fi[2];
    int         bi[2];
    int         wait_c[2];
    int         pref;
    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;

    always #5 clk = ~clk;

    mii_tx_arbiter #(
        .PREAMBLE_NIBBLES(PRE),
        .IFG_NIBBLES     (IFG)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req0_valid(req0_valid),
        .req0_data (req0_data),
        .req0_last (req0_last),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_data (req1_data),
        .req1_last (req1_last),
        .req1_ready(req1_ready),
        .mii_txd   (mii_txd),
        .mii_tx_en (mii_tx_en),
        .grant     (grant),
        .busy      (busy),
        .underrun  (underrun)
    );

    function automatic exp_t mk(input logic [2:0] k, input logic e,
                                input logic [3:0] d, input logic [1:0] gr,
                                input logic u, input logic [1:0] rd);
        exp_t x;
        x.kind = k;
        x.v    = {e, d, gr, 1'b1, u, rd};
        return x;
    endfunction

    // Whole expected trace of one granted frame, starting the cycle after
    // the arbitration edge.
    task automatic build_frame(input int g);
        logic [1:0] gb;
        logic [7:0] b;
        int         len, cut, m;
        gb  = (g == 0) ? 2'b01 : 2'b10;
        len = flen[g][fi[g]];
        cut = fcut[g][fi[g]];
        m   = (cut != 0) ? cut : len;
        for (int i = 0; i < PRE; i++) exp_q.push_back(mk(K_PRE, 1'b1, 4'h5, gb, 1'b0, 2'b00));
        exp_q.push_back(mk(K_SFD, 1'b1, 4'hD, gb, 1'b0, gb));
        for (int i = 0; i < m; i++) begin
            b = fb[g][fi[g]][i];
            exp_q.push_back(mk(K_LO, 1'b1, b[3:0], gb, 1'b0, 2'b00));
            exp_q.push_back(mk(K_HI, 1'b1, b[7:4], gb, 1'b0,
                               ((cut != 0) || (i < len - 1)) ? gb : 2'b00));
        end
        for (int j = 0; j < IFG; j++)
            exp_q.push_back(mk(K_IFG, 1'b0, 4'h0, gb, (cut != 0) && (j == 0), 2'b00));
    endtask

    task automatic next_frame(input int r, input int extra);
        fi[r]++;
        bi[r]     = 0;
        wait_c[r] = extra + ((fi[r] < nf[r]) ? fdly[r][fi[r]] : 0);
    endtask

    // One clock cycle; entered and left just after a falling edge.
    task automatic step(input bit force_rst, input bit rst_on_hi, output bit fired);
        exp_t        cur;
        logic [10:0] obs;
        logic        was_empty;
        logic        v, l;
        logic [7:0]  d;
        logic        acc[2];
        int          g;

        cur = (exp_q.size() != 0) ? exp_q[0] : '0;
        obs = {mii_tx_en, mii_txd, grant, busy, underrun, req1_ready, req0_ready};
        n_chk++;
        assert (obs === cur.v) else begin
            n_fail++;
            $error("FAIL cycle %0d trace: observed %h, expected %h (kind %0d)", cyc, obs, cur.v, cur.kind);
        end

        rst   = force_rst || (rst_on_hi && (cur.kind == K_HI));
        fired = rst;

        for (int r = 0; r < 2; r++) begin
            v = 1'b0;
            d = 8'($urandom);
            l = 1'($urandom);
            if ((fi[r] < nf[r]) && (wait_c[r] == 0)) begin
                v = 1'b1;
                d = fb[r][fi[r]][bi[r]];
                l = (bi[r] == flen[r][fi[r]] - 1);
            end
            if (r == 0) begin
                req0_valid = v; req0_data = d; req0_last = l;
            end else begin
                req1_valid = v; req1_data = d; req1_last = l;
            end
        end
        acc[0] = req0_valid && req0_ready;
        acc[1] = req1_valid && req1_ready;

        was_empty = (exp_q.size() == 0);
        if (was_empty && !rst && (req0_valid || req1_valid)) begin
            g = (req0_valid && req1_valid) ? pref : (req0_valid ? 0 : 1);
            build_frame(g);
            pref = 1 - g;
        end

        @(posedge clk);
        cyc++;
        if (rst) begin
            exp_q.delete();
            pref = 0;
            for (int r = 0; r < 2; r++) begin
                if (wait_c[r] > 0) wait_c[r]--;
                else if (bi[r] > 0) next_frame(r, 0);
            end
        end else begin
            if (!was_empty) exp_q.delete(0);
            for (int r = 0; r < 2; r++) begin
                if (wait_c[r] > 0) begin
                    wait_c[r]--;
                end else if (acc[r]) begin
                    bi[r]++;
                    if ((fcut[r][fi[r]] != 0) && (bi[r] == fcut[r][fi[r]])) next_frame(r, 2);
                    else if (bi[r] == flen[r][fi[r]]) next_frame(r, 0);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic clear_frames();
        for (int r = 0; r < 2; r++) begin
            nf[r] = 0; fi[r] = 0; bi[r] = 0; wait_c[r] = 0;
        end
    endtask

    task automatic add_frame(input int r, input int len, input int cut,
                             input int dly, input logic [63:0] bytes);
        for (int i = 0; i < 8; i++) fb[r][nf[r]][i] = bytes[8*i +: 8];
        flen[r][nf[r]] = len;
        fcut[r][nf[r]] = cut;
        fdly[r][nf[r]] = dly;
        nf[r]++;
    endtask

    task automatic start_frames();
        for (int r = 0; r < 2; r++) wait_c[r] = (nf[r] > 0) ? fdly[r][0] : 0;
    endtask

    task automatic run_phase(input int budget, input string name);
        int c;
        bit f;
        c = 0;
        while (!((fi[0] >= nf[0]) && (fi[1] >= nf[1]) && (exp_q.size() == 0)) && (c < budget)) begin
            step(1'b0, 1'b0, f);
            c++;
        end
        n_chk++;
        assert (c < budget) else begin
            n_fail++;
            $error("FAIL %s completion: observed %0d cycles, required fewer than %0d", name, c, budget);
        end
    endtask

    initial begin
        bit         f;
        int         c, len, cut, dly;
        logic [63:0] rb;

        rst = 1'b1;
        req0_valid = 1'b0; req0_data = 8'h00; req0_last = 1'b0;
        req1_valid = 1'b0; req1_data = 8'h00; req1_last = 1'b0;
        pref = 0;
        clear_frames();
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state held for a few idle cycles.
        repeat (3) step(1'b0, 1'b0, f);

        // Two-byte frame from requester 0.
        clear_frames();
        add_frame(0, 2, 0, 0, 64'h3CA1);
        start_frames();
        run_phase(200, "two_byte");

        // After reset both request: req0 first, then strict alternation.
        clear_frames();
        add_frame(0, 1, 0, 0, 64'h11);
        add_frame(0, 1, 0, 0, 64'h12);
        add_frame(0, 2, 0, 0, 64'h9913);
        add_frame(1, 1, 0, 0, 64'h21);
        add_frame(1, 3, 0, 0, 64'h442322);
        start_frames();
        step(1'b1, 1'b0, f);
        run_phase(600, "alternation");

        // Requester 1 starves after 0x55; requester 0 frame follows intact.
        clear_frames();
        add_frame(1, 2, 1, 0, 64'h6655);
        add_frame(0, 2, 0, 5, 64'h8877);
        start_frames();
        run_phase(300, "underrun");

        // Reset in the high-nibble cycle, then a fresh requester 1 frame.
        clear_frames();
        add_frame(0, 3, 0, 0, 64'hC3B2A1);
        start_frames();
        f = 1'b0;
        c = 0;
        while (!f && (c < 200)) begin
            step(1'b0, 1'b1, f);
            c++;
        end
        n_chk++;
        assert (f === 1'b1) else begin
            n_fail++;
            $error("FAIL mid_reset reached: observed %0d, expected 1", f);
        end
        add_frame(1, 2, 0, 0, 64'hE7D6);
        wait_c[1] = 0;
        run_phase(300, "after_reset");

        // Single-byte frame.
        clear_frames();
        add_frame(0, 1, 0, 0, 64'hFF);
        start_frames();
        run_phase(200, "single_byte");

        // Randomized traffic from both requesters, with occasional starvation.
        clear_frames();
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 12; k++) begin
                len = $urandom_range(1, 5);
                cut = 0;
                if ((len >= 2) && ($urandom_range(0, 4) == 0)) cut = $urandom_range(1, len - 1);
                dly = $urandom_range(0, 40);
                rb  = {$urandom, $urandom};
                add_frame(r, len, cut, dly, rb);
            end
        end
        start_frames();
        run_phase(8000, "random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mii_tx_arbiter.md
Name: mii_tx_arbiter

Overview:
Shares one MII transmit nibble interface between two byte-stream requesters, with frame-level round-robin arbitration. Inserts preamble and SFD, splits bytes into nibbles (low nibble first), and enforces the inter-frame gap. Sits between the MAC framers (or test traffic generators) and the registered MII TX output stage.

Parameters:
PREAMBLE_NIBBLES, 15, number of 4'h5 nibbles before the 4'hD SFD nibble
IFG_NIBBLES, 24, idle cycles (tx_en low) after each frame; must be >= 1

Ports:
clk  input  1  MII TX clock; all logic on posedge
rst  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 byte valid
req0_data  input  8  requester 0 byte
req0_last  input  1  requester 0 final byte of frame
req0_ready  output  1  requester 0 byte accepted (valid && ready)
req1_valid  input  1  requester 1 byte valid
req1_data  input  8  requester 1 byte
req1_last  input  1  requester 1 final byte of frame
req1_ready  output  1  requester 1 byte accepted
mii_txd  output  4  transmit nibble (registered)
mii_tx_en  output  1  transmit enable (registered)
grant  output  2  one-hot current owner; 2'b00 when idle
busy  output  1  high whenever state != IDLE
underrun  output  1  one-cycle pulse on a mid-frame valid drop

Behaviour:
- Reset (sync): state=IDLE, mii_txd=0, mii_tx_en=0, grant=0, busy=0, underrun=0, RR pointer prefers req0. reqN_ready=0 whenever state is not SFD or DATA.
- States: IDLE, PREAMBLE, SFD, DATA_LO, DATA_HI, IFG.
- IDLE: if any reqN_valid at edge T, grant the one chosen by RR. Both valid -> the one not served last (req0 after reset). Single valid -> that one.
- At T+1: grant set, busy=1, mii_tx_en=1, mii_txd=5. PREAMBLE runs PREAMBLE_NIBBLES cycles (T+1..T+15 at default), driving 4'h5.
- SFD (T+16): mii_txd=4'hD. The granted reqN_ready is high this cycle (combinational from state and grant).
- DATA_LO: drive captured byte[3:0]. Next state DATA_HI.
- DATA_HI: drive byte[7:4]. The granted ready is high this cycle.
- Bytes are captured on edges where ready && valid.
- If the captured byte had last=1, the next state is IFG instead of DATA_LO. The next byte is captured at the end of DATA_HI only if the current byte was not last.
- The non-granted requester's ready is always 0.
- Underrun: in SFD or DATA_HI of a non-last byte, if the granted valid=0 at the edge:
  - no byte is captured; underrun pulses next cycle;
  - mii_tx_en drops next cycle (truncated frame); state goes to IFG.
- IFG: mii_tx_en=0, mii_txd=0 for IFG_NIBBLES cycles.
  - grant stays set through IFG; the RR pointer updates to favour the other requester on IFG entry.
  - Then IDLE, grant=0, busy=0.
  - Requests asserted during IFG wait; arbitration happens only in IDLE.
- Throughput: one byte per 2 clocks; tx_en high for 16 + 2*N cycles for an N-byte frame.
- Reset mid-frame: outputs return to reset values on the next edge; any partial frame is abandoned.
- reqN_data and reqN_last are sampled only on an accepting edge.

Test Plan:
- req0 sends 0xA1, 0x3C(last) -> txd = 5 x15, D, 1, A, C, 3; tx_en high 20 cycles, then low 24 cycles; grant=01 throughout; busy falls after IFG.
- After reset, req0 and req1 both valid with 1-byte frames -> req0 frame first; req1 preamble starts exactly 1 cycle after IFG ends; grant=10 for the second frame.
- req0 re-requests immediately while req1 waits -> req1 granted next; then req0 (strict alternation).
- req1 drops valid before its second byte (frame 0x55, gap) -> underrun pulses once; tx_en low after 0x55's high nibble; IFG follows; no byte lost from req0.
- rst asserted during DATA_HI -> next cycle tx_en=0, grant=0, busy=0; a new req1 frame afterwards starts with the full preamble.
- Single-byte frame 0xFF(last) -> 18 tx_en cycles, exactly one ready pulse during SFD.
